// File: rtl/complex_addsub_pipe_pkg.sv
// Shared FFT datapath helpers: complex field packing and the W+1 -> W
// reduction (scale / saturate / wrap) used by the butterfly add/sub unit.
// Functions work on a fixed maximum width and take the live width as an
// argument, so callers size-cast their operands in and results out.
package fft_pkg;

  localparam int MAXW = 32;

  typedef logic signed [MAXW:0] raw_t;

  typedef struct packed {
    logic [MAXW-1:0] val;
    logic            ovf;
  } red_t;

  function automatic logic [2*MAXW-1:0] cplx_mask(input int w);
    return ((2*MAXW)'(1) << w) - (2*MAXW)'(1);
  endfunction

  function automatic logic [MAXW-1:0] cplx_re(input logic [2*MAXW-1:0] x, input int w);
    return MAXW'((x >> w) & cplx_mask(w));
  endfunction

  function automatic logic [MAXW-1:0] cplx_im(input logic [2*MAXW-1:0] x, input int w);
    return MAXW'(x & cplx_mask(w));
  endfunction

  function automatic logic [2*MAXW-1:0] cplx_pack(input logic [MAXW-1:0] re,
                                                  input logic [MAXW-1:0] im,
                                                  input int w);
    logic [2*MAXW-1:0] m;
    m = cplx_mask(w);
    return (((2*MAXW)'(re) & m) << w) | ((2*MAXW)'(im) & m);
  endfunction

  // raw must already be sign-extended to MAXW+1 bits. Wrap keeps the low
  // bits untouched, so the caller's low-w slice is the wrapped value.
  function automatic red_t reduce(input raw_t raw, input int w,
                                  input logic scale, input logic sat_en);
    raw_t pos_max;
    raw_t neg_min;
    red_t r;
    pos_max = (raw_t'(1) <<< (w - 1)) - raw_t'(1);
    neg_min = -(raw_t'(1) <<< (w - 1));
    r.ovf = 1'b0;
    r.val = MAXW'(raw);
    if (scale) begin
      r.val = MAXW'(raw >>> 1);
    end else if (raw > pos_max) begin
      r.ovf = 1'b1;
      if (sat_en) r.val = MAXW'(pos_max);
    end else if (raw < neg_min) begin
      r.ovf = 1'b1;
      if (sat_en) r.val = MAXW'(neg_min);
    end
    return r;
  endfunction

endpackage

// File: rtl/complex_addsub_pipe_if.sv
// Operand / result handshake bundle for complex_addsub_pipe.
interface complex_addsub_pipe_if #(parameter int W = 8);
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] in_a;
  logic [2*W-1:0] in_b;
  logic           in_scale;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_sum;
  logic [2*W-1:0] out_diff;
  logic           ovf_flag;
  logic           ovf_clr;

  modport master (
    output in_valid, in_a, in_b, in_scale, out_ready, ovf_clr,
    input  in_ready, out_valid, out_sum, out_diff, ovf_flag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_scale, out_ready, ovf_clr,
    output in_ready, out_valid, out_sum, out_diff, ovf_flag
  );
endinterface

// File: rtl/complex_addsub_pipe_reduce.sv
// cplx_reduce: combinational W+1 -> W reduction of one raw component.
// Build option COMPLEX_ADDSUB_SAT_EN: defined -> overflowed components
// saturate; undefined -> they wrap to raw[W-1:0]. The ovf bit is the same
// in both builds.
module cplx_reduce
  import fft_pkg::*;
#(
  parameter int W = 8
) (
  input  logic signed [W:0]   raw,
  input  logic                scale,
  output logic        [W-1:0] res,
  output logic                ovf
);

`ifdef COMPLEX_ADDSUB_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  red_t red;

  // Sign-extend into the shared reduce function and trim back to W bits.
  always_comb begin
    red = reduce(raw_t'(raw), W, scale, SAT_EN);
    res = W'(red.val);
    ovf = red.ovf;
  end

endmodule

// File: rtl/complex_addsub_pipe.sv
// complex_addsub_pipe: two-stage radix-2 butterfly add/sub with valid/ready
// on both sides. S1 registers the W+1-bit raw sums/differences, S2 reduces
// them to W bits (see cplx_reduce for the COMPLEX_ADDSUB_SAT_EN option).
module complex_addsub_pipe
  import fft_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  complex_addsub_pipe_if.slave bus
);

  logic s1_valid, s2_valid;
  logic s1_load, s2_load;
  logic s1_scale;

  logic signed [W-1:0] a_re, a_im, b_re, b_im;
  logic signed [W:0]   raw_sum_re, raw_sum_im, raw_dif_re, raw_dif_im;
  logic signed [W:0]   s1_sum_re, s1_sum_im, s1_dif_re, s1_dif_im;

  logic [W-1:0] r_sum_re, r_sum_im, r_dif_re, r_dif_im;
  logic [3:0]   r_ovf;

  logic [2*W-1:0] sum_q, diff_q;
  logic           ovf_q;

  // Stage advance: in_ready ripples back combinationally from out_ready.
  always_comb begin
    s2_load      = !s2_valid || bus.out_ready;
    s1_load      = !s1_valid || s2_load;
    bus.in_ready = s1_load;
  end

  // Split operands and form sign-extended raw sums and differences.
  always_comb begin
    a_re = W'(cplx_re((2*MAXW)'(bus.in_a), W));
    a_im = W'(cplx_im((2*MAXW)'(bus.in_a), W));
    b_re = W'(cplx_re((2*MAXW)'(bus.in_b), W));
    b_im = W'(cplx_im((2*MAXW)'(bus.in_b), W));
    raw_sum_re = {a_re[W-1], a_re} + {b_re[W-1], b_re};
    raw_sum_im = {a_im[W-1], a_im} + {b_im[W-1], b_im};
    raw_dif_re = {a_re[W-1], a_re} - {b_re[W-1], b_re};
    raw_dif_im = {a_im[W-1], a_im} - {b_im[W-1], b_im};
  end

  // S1: capture raw results and the scale request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_scale  <= 1'b0;
      s1_sum_re <= '0;
      s1_sum_im <= '0;
      s1_dif_re <= '0;
      s1_dif_im <= '0;
    end else if (s1_load) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_scale  <= bus.in_scale;
        s1_sum_re <= raw_sum_re;
        s1_sum_im <= raw_sum_im;
        s1_dif_re <= raw_dif_re;
        s1_dif_im <= raw_dif_im;
      end
    end
  end

  cplx_reduce #(.W(W)) u_red_sum_re (.raw(s1_sum_re), .scale(s1_scale), .res(r_sum_re), .ovf(r_ovf[0]));
  cplx_reduce #(.W(W)) u_red_sum_im (.raw(s1_sum_im), .scale(s1_scale), .res(r_sum_im), .ovf(r_ovf[1]));
  cplx_reduce #(.W(W)) u_red_dif_re (.raw(s1_dif_re), .scale(s1_scale), .res(r_dif_re), .ovf(r_ovf[2]));
  cplx_reduce #(.W(W)) u_red_dif_im (.raw(s1_dif_im), .scale(s1_scale), .res(r_dif_im), .ovf(r_ovf[3]));

  // S2: register the reduced pair; data only moves when a valid pair loads,
  // so the outputs stay put while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      sum_q    <= '0;
      diff_q   <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        sum_q  <= (2*W)'(cplx_pack(MAXW'(r_sum_re), MAXW'(r_sum_im), W));
        diff_q <= (2*W)'(cplx_pack(MAXW'(r_dif_re), MAXW'(r_dif_im), W));
      end
    end
  end

  // Sticky overflow: a pair loading S2 with any overflowed component beats clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (s2_load && s1_valid && (|r_ovf)) begin
      ovf_q <= 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.out_sum   = sum_q;
  assign bus.out_diff  = diff_q;
  assign bus.ovf_flag  = ovf_q;

endmodule

// File: tb/tb_complex_addsub_pipe.sv
// Directed bench for complex_addsub_pipe at W=8; expectations follow the
// build option COMPLEX_ADDSUB_SAT_EN.
module tb_complex_addsub_pipe;

  localparam int W = 8;

`ifdef COMPLEX_ADDSUB_SAT_EN
  localparam int OVF_POS = 127;
  localparam int OVF_NEG = -128;
`else
  localparam int OVF_POS = -106;
  localparam int OVF_NEG = 106;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  complex_addsub_pipe_if #(.W(W)) bus ();

  complex_addsub_pipe #(.W(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Stream table: A=(a_re,a_im), B=(b_re,b_im), hand-computed sum/diff.
  int sa_re[10] = '{1, -5, 20, -64, 127, 7, -100, 33, -1, 60};
  int sa_im[10] = '{2, 6, 30, 64, -128, -7, 50, 44, -1, -60};
  int sb_re[10] = '{3, 2, 10, -64, 0, 7, 27, -33, -1, 60};
  int sb_im[10] = '{4, -3, -10, 63, 0, 7, -50, -44, -1, -60};
  int ss_re[10] = '{4, -3, 30, -128, 127, 14, -73, 0, -2, 120};
  int ss_im[10] = '{6, 3, 20, 127, -128, 0, 0, 0, -2, -120};
  int sd_re[10] = '{-2, -7, 10, 0, 127, 0, -127, 66, 0, 0};
  int sd_im[10] = '{-2, 9, 40, 1, -128, -14, 100, 88, 0, 0};

  function automatic logic [15:0] cp(input int re, input int im);
    return {8'(re), 8'(im)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offer one operand with the sink ready; leaves the bench just after the accepting edge.
  task automatic send_one(input logic [15:0] a, input logic [15:0] b, input logic sc);
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_scale  = sc;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("early_valid", bus.out_valid, 1'b0);
  endtask

  task automatic get_one(input string tag, input logic [15:0] es, input logic [15:0] ed);
    int k;
    k = 0;
    while (!bus.out_valid && k < 6) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk({tag, "_valid"}, bus.out_valid, 1'b1);
    chk({tag, "_sum"}, bus.out_sum, es);
    chk({tag, "_diff"}, bus.out_diff, ed);
  endtask

  task automatic clear_ovf();
    @(negedge clk);
    bus.ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.ovf_clr = 1'b0;
    chk("ovf_cleared", bus.ovf_flag, 1'b0);
  endtask

  initial begin
    int acc_i, cons_i, cyc, occ;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_scale  = 1'b0;
    bus.out_ready = 1'b0;
    bus.ovf_clr   = 1'b0;

    #12;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_sum", bus.out_sum, 16'h0);
    chk("rst_out_diff", bus.out_diff, 16'h0);
    chk("rst_ovf", bus.ovf_flag, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    send_one(cp(10, -20), cp(5, 7), 1'b0);
    get_one("basic", cp(15, -13), cp(5, -27));
    chk("basic_ovf", bus.ovf_flag, 1'b0);

    send_one(cp(100, -20), cp(50, 10), 1'b0);
    get_one("ovf_pos", cp(OVF_POS, -10), cp(50, -30));
    @(posedge clk);
    #1;
    chk("ovf_set", bus.ovf_flag, 1'b1);
    @(posedge clk);
    #1;
    chk("ovf_sticky", bus.ovf_flag, 1'b1);
    clear_ovf();

    send_one(cp(-100, 0), cp(50, 0), 1'b0);
    get_one("ovf_neg", cp(-50, 0), cp(OVF_NEG, 0));
    @(posedge clk);
    #1;
    chk("ovf_neg_set", bus.ovf_flag, 1'b1);
    clear_ovf();

    send_one(cp(100, -20), cp(50, 10), 1'b1);
    get_one("scaled", cp(75, -5), cp(25, -15));
    send_one(cp(-1, 0), cp(0, 0), 1'b1);
    get_one("trunc", cp(-1, 0), cp(-1, 0));
    @(posedge clk);
    #1;
    chk("scaled_no_ovf", bus.ovf_flag, 1'b0);

    // Set wins: clear held on the edge where the overflowed pair loads S2.
    send_one(cp(100, 0), cp(50, 0), 1'b0);
    @(negedge clk);
    bus.ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.ovf_clr = 1'b0;
    chk("setwins_valid", bus.out_valid, 1'b1);
    chk("setwins_ovf", bus.ovf_flag, 1'b1);
    clear_ovf();

    // Random-backpressure stream of 10 operands, checked in order.
    acc_i = 0;
    cons_i = 0;
    cyc = 0;
    while (cons_i < 10 && cyc < 200) begin
      @(negedge clk);
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.in_valid  = (acc_i < 10);
      bus.in_scale  = 1'b0;
      if (acc_i < 10) begin
        bus.in_a = cp(sa_re[acc_i], sa_im[acc_i]);
        bus.in_b = cp(sb_re[acc_i], sb_im[acc_i]);
      end
      #1;
      occ = acc_i - cons_i;
      chk("stream_in_ready", bus.in_ready, !(occ == 2 && !bus.out_ready));
      if (bus.out_valid && bus.out_ready) begin
        chk("stream_sum", bus.out_sum, cp(ss_re[cons_i], ss_im[cons_i]));
        chk("stream_diff", bus.out_diff, cp(sd_re[cons_i], sd_im[cons_i]));
        cons_i++;
      end
      if (bus.in_valid && bus.in_ready) acc_i++;
      cyc++;
    end
    chk("stream_count", cons_i, 10);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("stream_no_dup", bus.out_valid, 1'b0);

    // Fill both stages with the sink stalled, then reset asynchronously.
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_a      = cp(1, 1);
    bus.in_b      = cp(1, 1);
    @(posedge clk);
    #1;
    bus.in_a = cp(2, 2);
    bus.in_b = cp(0, 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("full_valid", bus.out_valid, 1'b1);
    chk("full_in_ready", bus.in_ready, 1'b0);
    chk("full_sum", bus.out_sum, cp(2, 2));
    @(posedge clk);
    #1;
    chk("stall_hold_sum", bus.out_sum, cp(2, 2));
    chk("stall_hold_diff", bus.out_diff, cp(0, 0));
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", bus.out_valid, 1'b0);
    chk("async_rst_sum", bus.out_sum, 16'h0);
    chk("async_rst_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst_idle", bus.out_valid, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
